// File: rtl/load_store_buffer_pkg.sv
// Shared definitions for the load/store buffer:
// opcode encodings, default sizes, FSM states and opcode helpers.
package load_store_buffer_pkg;

    localparam int LSB_SIZE_DEF  = 8;
    localparam int ROB_IDX_W_DEF = 4;

    localparam logic [5:0] OP_LB  = 6'd1;
    localparam logic [5:0] OP_LH  = 6'd2;
    localparam logic [5:0] OP_LW  = 6'd3;
    localparam logic [5:0] OP_LBU = 6'd4;
    localparam logic [5:0] OP_LHU = 6'd5;
    localparam logic [5:0] OP_SB  = 6'd6;
    localparam logic [5:0] OP_SH  = 6'd7;
    localparam logic [5:0] OP_SW  = 6'd8;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_FLUSH_WAIT
    } lsb_state_e;

    function automatic logic op_is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic [1:0] op_size(input logic [5:0] op);
        logic [1:0] sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
            default:              sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/load_store_buffer_load_ext.sv
// Load result extension: sign/zero-extends the low-aligned
// memory data according to the load opcode.
module lsb_load_ext
    import load_store_buffer_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    // Pick the extension for the access width and signedness
    always_comb begin
        data = rdata;
        case (op)
            OP_LB:   data = {{24{rdata[7]}}, rdata[7:0]};
            OP_LH:   data = {{16{rdata[15]}}, rdata[15:0]};
            OP_LBU:  data = {24'd0, rdata[7:0]};
            OP_LHU:  data = {16'd0, rdata[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue: operand wakeup, store commit tracking,
// head-only memory issue and mispredict flush of uncommitted entries.
module load_store_buffer
    import load_store_buffer_pkg::*;
#(
    parameter int LSB_SIZE  = LSB_SIZE_DEF,
    parameter int ROB_IDX_W = ROB_IDX_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 jp_wrong,
    input  logic                 ins_flag,
    input  logic [5:0]           insty,
    input  logic [ROB_IDX_W-1:0] rob_idx,
    input  logic                 rs1_ready,
    input  logic [31:0]          reg1,
    input  logic                 rs2_ready,
    input  logic [31:0]          reg2,
    input  logic [31:0]          imm,
    input  logic                 ari_flag,
    input  logic [ROB_IDX_W-1:0] ari_idx,
    input  logic [31:0]          ari_val,
    input  logic                 store_flag,
    output logic                 LSB_full,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [1:0]           mem_size,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_done,
    input  logic [31:0]          mem_rdata,
    output logic                 val_flag_LSB,
    output logic [ROB_IDX_W-1:0] val_idx_LSB,
    output logic [31:0]          val_LSB
);

    localparam int PTR_W = $clog2(LSB_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LSB_SIZE);

    logic [PTR_W-1:0] head_q, head_d, rear_q, rear_d;
    logic [CNT_W-1:0] count_q, count_d, ccnt_q, ccnt_d, ccnt_n;

    logic                 valid_q  [LSB_SIZE];
    logic                 valid_d  [LSB_SIZE];
    logic                 commit_q [LSB_SIZE];
    logic                 commit_d [LSB_SIZE];
    logic [5:0]           op_q     [LSB_SIZE];
    logic [5:0]           op_d     [LSB_SIZE];
    logic [ROB_IDX_W-1:0] rob_q    [LSB_SIZE];
    logic [ROB_IDX_W-1:0] rob_d    [LSB_SIZE];
    logic                 r1_rdy_q [LSB_SIZE];
    logic                 r1_rdy_d [LSB_SIZE];
    logic [31:0]          r1_q     [LSB_SIZE];
    logic [31:0]          r1_d     [LSB_SIZE];
    logic                 r2_rdy_q [LSB_SIZE];
    logic                 r2_rdy_d [LSB_SIZE];
    logic [31:0]          r2_q     [LSB_SIZE];
    logic [31:0]          r2_d     [LSB_SIZE];
    logic [31:0]          imm_q    [LSB_SIZE];
    logic [31:0]          imm_d    [LSB_SIZE];

    lsb_state_e state_q, state_d;

    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [1:0]           mem_size_q, mem_size_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;
    logic                 val_flag_q, val_flag_d;
    logic [ROB_IDX_W-1:0] val_idx_q, val_idx_d;
    logic [31:0]          val_q, val_d;

    logic             full, enq, deq, issue;
    logic             h_ready, h_store, h_load;
    logic [5:0]       h_op;
    logic [PTR_W-1:0] ctgt, off;
    logic             set_commit, deq_commit;
    logic             in_r1_rdy, in_r2_rdy;
    logic [31:0]      in_r1, in_r2, ext_data;

    assign full    = (count_q == FULL_CNT);
    assign h_op    = op_q[head_q];
    assign h_store = op_is_store(h_op);
    assign h_load  = op_is_load(h_op);
    assign h_ready = valid_q[head_q] && r1_rdy_q[head_q] && r2_rdy_q[head_q];

    // A flush blocks a load from starting; committed stores survive it
    assign issue = (state_q == ST_IDLE) && h_ready &&
                   ((h_load && !jp_wrong) || (h_store && commit_q[head_q]));

    assign deq = (state_q == ST_BUSY) && mem_done;
    assign enq = ins_flag && !jp_wrong && (!full || deq);

    // Oldest uncommitted store sits right after the committed prefix
    assign ctgt       = head_q + ccnt_q[PTR_W-1:0];
    assign set_commit = store_flag && (ccnt_q < count_q) && valid_q[ctgt] &&
                        !commit_q[ctgt] && op_is_store(op_q[ctgt]);
    assign deq_commit = deq && commit_q[head_q];
    assign ccnt_n     = ccnt_q + CNT_W'(set_commit) - CNT_W'(deq_commit);

    lsb_load_ext u_ext (
        .op    (h_op),
        .rdata (mem_rdata),
        .data  (ext_data)
    );

    // Wake up the operands of the incoming entry from this cycle's broadcasts
    always_comb begin
        in_r1_rdy = rs1_ready;
        in_r1     = reg1;
        in_r2_rdy = rs2_ready;
        in_r2     = reg2;
        if (!rs1_ready && ari_flag && reg1[ROB_IDX_W-1:0] == ari_idx) begin
            in_r1_rdy = 1'b1;
            in_r1     = ari_val;
        end else if (!rs1_ready && val_flag_q &&
                     reg1[ROB_IDX_W-1:0] == val_idx_q) begin
            in_r1_rdy = 1'b1;
            in_r1     = val_q;
        end
        if (!rs2_ready && ari_flag && reg2[ROB_IDX_W-1:0] == ari_idx) begin
            in_r2_rdy = 1'b1;
            in_r2     = ari_val;
        end else if (!rs2_ready && val_flag_q &&
                     reg2[ROB_IDX_W-1:0] == val_idx_q) begin
            in_r2_rdy = 1'b1;
            in_r2     = val_q;
        end
    end

    // Queue pointers, entry wakeup, commit marking, enqueue and flush
    always_comb begin
        head_d   = head_q + PTR_W'(deq);
        ccnt_d   = ccnt_n;
        off      = '0;
        valid_d  = valid_q;
        commit_d = commit_q;
        op_d     = op_q;
        rob_d    = rob_q;
        r1_rdy_d = r1_rdy_q;
        r1_d     = r1_q;
        r2_rdy_d = r2_rdy_q;
        r2_d     = r2_q;
        imm_d    = imm_q;
        if (jp_wrong) begin
            count_d = ccnt_n;
            rear_d  = head_d + ccnt_n[PTR_W-1:0];
        end else begin
            count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
            rear_d  = rear_q + PTR_W'(enq);
        end
        for (int i = 0; i < LSB_SIZE; i++) begin
            if (!r1_rdy_q[i] && ari_flag &&
                r1_q[i][ROB_IDX_W-1:0] == ari_idx) begin
                r1_rdy_d[i] = 1'b1;
                r1_d[i]     = ari_val;
            end else if (!r1_rdy_q[i] && val_flag_q &&
                         r1_q[i][ROB_IDX_W-1:0] == val_idx_q) begin
                r1_rdy_d[i] = 1'b1;
                r1_d[i]     = val_q;
            end
            if (!r2_rdy_q[i] && ari_flag &&
                r2_q[i][ROB_IDX_W-1:0] == ari_idx) begin
                r2_rdy_d[i] = 1'b1;
                r2_d[i]     = ari_val;
            end else if (!r2_rdy_q[i] && val_flag_q &&
                         r2_q[i][ROB_IDX_W-1:0] == val_idx_q) begin
                r2_rdy_d[i] = 1'b1;
                r2_d[i]     = val_q;
            end
        end
        if (set_commit) begin
            commit_d[ctgt] = 1'b1;
        end
        if (enq) begin
            commit_d[rear_q] = 1'b0;
            op_d[rear_q]     = insty;
            rob_d[rear_q]    = rob_idx;
            r1_rdy_d[rear_q] = in_r1_rdy;
            r1_d[rear_q]     = in_r1;
            r2_rdy_d[rear_q] = in_r2_rdy;
            r2_d[rear_q]     = in_r2;
            imm_d[rear_q]    = imm;
        end
        for (int i = 0; i < LSB_SIZE; i++) begin
            off        = PTR_W'(i) - head_d;
            valid_d[i] = ({1'b0, off} < count_d);
            if (!valid_d[i]) begin
                commit_d[i] = 1'b0;
            end
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (issue) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (mem_done) state_d = ST_IDLE;
                else if (jp_wrong && !mem_we_q) state_d = ST_FLUSH_WAIT;
            end
            ST_FLUSH_WAIT: begin
                if (mem_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: memory request and load result broadcast
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_size_d  = mem_size_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        val_flag_d  = 1'b0;
        val_idx_d   = val_idx_q;
        val_d       = val_q;
        unique case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = h_store;
                    mem_size_d  = op_size(h_op);
                    mem_addr_d  = r1_q[head_q] + imm_q[head_q];
                    mem_wdata_d = r2_q[head_q];
                end
            end
            ST_BUSY: begin
                if (mem_done) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q && !jp_wrong) begin
                        val_flag_d = 1'b1;
                        val_idx_d  = rob_q[head_q];
                        val_d      = ext_data;
                    end
                end
            end
            ST_FLUSH_WAIT: begin
                if (mem_done) mem_req_d = 1'b0;
            end
            default: mem_req_d = 1'b0;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q      <= '0;
            rear_q      <= '0;
            count_q     <= '0;
            ccnt_q      <= '0;
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            val_flag_q  <= 1'b0;
            val_idx_q   <= '0;
            val_q       <= '0;
            for (int i = 0; i < LSB_SIZE; i++) begin
                valid_q[i]  <= 1'b0;
                commit_q[i] <= 1'b0;
                op_q[i]     <= '0;
                rob_q[i]    <= '0;
                r1_rdy_q[i] <= 1'b0;
                r1_q[i]     <= '0;
                r2_rdy_q[i] <= 1'b0;
                r2_q[i]     <= '0;
                imm_q[i]    <= '0;
            end
        end else begin
            head_q      <= head_d;
            rear_q      <= rear_d;
            count_q     <= count_d;
            ccnt_q      <= ccnt_d;
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_size_q  <= mem_size_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            val_flag_q  <= val_flag_d;
            val_idx_q   <= val_idx_d;
            val_q       <= val_d;
            valid_q     <= valid_d;
            commit_q    <= commit_d;
            op_q        <= op_d;
            rob_q       <= rob_d;
            r1_rdy_q    <= r1_rdy_d;
            r1_q        <= r1_d;
            r2_rdy_q    <= r2_rdy_d;
            r2_q        <= r2_d;
            imm_q       <= imm_d;
        end
    end

    assign LSB_full     = full;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_size     = mem_size_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign val_flag_LSB = val_flag_q;
    assign val_idx_LSB  = val_idx_q;
    assign val_LSB      = val_q;

endmodule
